// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus of the shared memory port arbiter.
// slave is the arbiter view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        resp;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [IW-1:0]             grant_id;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata,
    input  mem_ready, mem_rdata,
    output resp, err, rdata, busy, grant_id,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata,
    output mem_ready, mem_rdata,
    input  resp, err, rdata, busy, grant_id,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to abort accesses stalled for TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: unsupported NUM_REQ/TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gid;
  logic [IW-1:0]      pick;
  logic               hit;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] gsel;
  logic               timed_out;

  // First requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    pick = ptr;
    hit  = 1'b0;
    sum  = '0;
    idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hit) state_nx = BUS;
      BUS:     if (bus.mem_ready || timed_out)
                 state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr         <= '0;
      gid         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (state == IDLE && hit) begin
        gid         <= pick;
        mem_we_q    <= bus.we[pick];
        mem_addr_q  <= bus.addr[pick*ADDR_W +: ADDR_W];
        mem_wdata_q <= bus.wdata[pick*DATA_W +: DATA_W];
      end
      if (state == BUS && bus.mem_ready && !mem_we_q)
        rdata_q <= bus.mem_rdata;
      if (state == DONE)
        ptr <= (gid == IW'(NUM_REQ-1)) ? '0 : gid + 1'b1;
    end
  end

  assign gsel = NUM_REQ'(1) << gid;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // mem_ready in the final cycle still wins over the timeout
  assign timed_out = (state == BUS) && !bus.mem_ready &&
                     (cnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != BUS) cnt <= '0;
      else              cnt <= cnt + 1'b1;
      if (state == BUS) err_q <= timed_out;
    end
  end

  assign bus.err = (state == DONE && err_q) ? gsel : '0;
`else
  assign timed_out = 1'b0;
  assign bus.err   = '0;
`endif

  assign bus.resp      = (state == DONE) ? gsel : '0;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.grant_id  = gid;
  assign bus.mem_req   = (state == BUS);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences,
// and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 16;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  int  rdy_delay = 0;
  bit  rand_mode = 1'b0;
  int  wcnt = 0;
  int  cur_delay = 0;
  int  got_g[$];

  typedef struct {
    int            r;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 40503) ^ 16'hC0DE;
  endfunction

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory device: answers after a delay, random noise while idle
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wcnt == 0)
        cur_delay = rand_mode ? int'($urandom_range(0, 3)) : rdy_delay;
      if (wcnt >= cur_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr];
        if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = DW'($urandom);
      end
      wcnt++;
    end else begin
      wcnt = 0;
      bus.mem_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rdata = DW'($urandom);
    end
  end

  task automatic do_txn(input string nm, input int r, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int dly, input logic [DW-1:0] exp_rd);
    int n;
    logic [N-1:0] eresp;
    rdy_delay = dly;
    bus.we[r] = w;
    bus.addr[r*AW +: AW] = a;
    bus.wdata[r*DW +: DW] = d;
    bus.req[r] = 1'b1;
    step();
    check({nm, " mem_req"}, bus.mem_req, 1);
    check({nm, " grant"}, bus.grant_id, r);
    check({nm, " mem_we"}, bus.mem_we, w);
    check({nm, " mem_addr"}, bus.mem_addr, a);
    if (w) check({nm, " mem_wdata"}, bus.mem_wdata, d);
    n = 1;
    do begin
      step();
      n++;
      if (bus.resp == '0)
        check({nm, " hold"}, {bus.mem_req, bus.mem_addr, bus.busy},
              {1'b1, a, 1'b1});
    end while (bus.resp == '0 && n < dly + 20);
    eresp = '0;
    eresp[r] = 1'b1;
    check({nm, " latency"}, n, dly + 2);
    check({nm, " resp"}, bus.resp, eresp);
    check({nm, " rdata"}, bus.rdata, exp_rd);
    check({nm, " busy"}, bus.busy, 1);
    bus.req[r] = 1'b0;
    step();
    check({nm, " idle"}, {bus.resp, bus.busy, bus.mem_req}, 0);
  endtask

  task automatic run_grants(input logic [N-1:0] mask, input int n);
    int   done;
    int   cyc;
    logic pm;
    done = 0;
    cyc  = 0;
    pm   = 1'b0;
    got_g.delete();
    bus.req = mask;
    while (done < n && cyc < 40 * n) begin
      step();
      cyc++;
      if (bus.mem_req && !pm) got_g.push_back(int'(bus.grant_id));
      pm = bus.mem_req;
      if (bus.resp != '0) begin
        done++;
        bus.req = (done < n) ? (mask & ~bus.resp) : '0;
      end else if (done < n) begin
        bus.req = mask;
      end
    end
    check("grants completed", done, n);
    step();
  endtask

  initial begin
    int            g;
    int            ptr_m;
    int            inflight;
    int            jd;
    int            quiet;
    int            nresp;
    logic          pm;
    bit            abort;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] last_rd;
    logic [DW-1:0] rd_before;
    logic [N-1:0]  eresp;
    logic [DW-1:0] model [16];
    int            exp_rr [6];

    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = init_val(i);
    mem_arr[5] = 16'h1234;

    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;

    tbl[0] = '{0, 1'b0, 14'h0005, 16'h0000, 0, 16'h1234};
    tbl[1] = '{2, 1'b1, 14'h3FFF, 16'hBEEF, 0, 16'h1234};
    tbl[2] = '{2, 1'b0, 14'h3FFF, 16'h0000, 0, 16'hBEEF};
    tbl[3] = '{0, 1'b0, 14'h0005, 16'h0000, 10, 16'h1234};
    tbl[4] = '{1, 1'b1, 14'h0010, 16'h00A5, 1, 16'h1234};
    tbl[5] = '{3, 1'b0, 14'h0010, 16'h0000, 2, 16'h00A5};

    reset_n = 1'b0;
    step(); step(); step();
    check("reset outputs",
          {bus.resp, bus.err, bus.rdata, bus.busy, bus.grant_id,
           bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      do_txn($sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a,
             tbl[i].d, tbl[i].dly, tbl[i].exp_rd);

    rdy_delay = 1;
    exp_rr = '{0, 1, 2, 3, 0, 1};
    run_grants(4'b1111, 6);
    check("rr count", got_g.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr grant%0d", i),
            (i < got_g.size()) ? got_g[i] : -1, exp_rr[i]);
      if (i > 0 && i < got_g.size())
        check($sformatf("rr distinct%0d", i), got_g[i] != got_g[i-1], 1);
    end

    run_grants(4'b0011, 2);
    check("skip count", got_g.size(), 2);
    check("skip grant0", (got_g.size() > 0) ? got_g[0] : -1, 0);
    check("skip grant1", (got_g.size() > 1) ? got_g[1] : -1, 1);

    rdy_delay = 1000;
    bus.we[2] = 1'b0;
    bus.addr[2*AW +: AW] = 14'h0005;
    bus.req = 4'b0100;
    step();
    check("rst grant", {bus.mem_req, bus.grant_id}, {1'b1, 2'd2});
    step();
    step();
    reset_n = 1'b0;
    bus.req = '0;
    step();
    check("rst in bus",
          {bus.mem_req, bus.resp, bus.busy, bus.grant_id}, 0);
    reset_n = 1'b1;
    rdy_delay = 0;
    step();
    check("rst no resp", {bus.resp, bus.busy}, 0);
    run_grants(4'b1101, 1);
    check("rst next grant", (got_g.size() > 0) ? got_g[0] : -1, 0);

`ifdef ARB_TIMEOUT_EN
    rdy_delay = 100000;
    rd_before = bus.rdata;
    bus.we[1] = 1'b0;
    bus.addr[1*AW +: AW] = 14'h0005;
    bus.req = 4'b0010;
    step();
    check("to mem_req", bus.mem_req, 1);
    for (int k = 1; k < TO; k++) begin
      step();
      check("to wait", {bus.resp, bus.err, bus.mem_req},
            {4'b0000, 4'b0000, 1'b1});
    end
    step();
    check("to resp err", {bus.resp, bus.err}, {4'b0010, 4'b0010});
    check("to rdata", bus.rdata, rd_before);
    bus.req = '0;
    step();
    check("to after", {bus.resp, bus.err, bus.mem_req}, 0);
    rdy_delay = 0;
`endif

    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    rand_mode = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = init_val(256 + i);
    ptr_m = 0;
    pm = 1'b0;
    inflight = -1;
    quiet = 0;
    nresp = 0;
    abort = 1'b0;
    last_rd = '0;
    e_we = 1'b0;
    e_addr = '0;
    e_wd = '0;
    for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
      step();
      jd = -1;
      if (bus.mem_req && !pm) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        check("rnd grant", bus.grant_id, g);
        if (g >= 0) begin
          e_we   = bus.we[g];
          e_addr = bus.addr[g*AW +: AW];
          e_wd   = bus.wdata[g*DW +: DW];
          inflight = g;
        end
      end
      if (bus.mem_req)
        check("rnd mem cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
              {e_we, e_addr, e_wd});
      if (bus.resp != '0) begin
        eresp = '0;
        if (inflight >= 0) eresp[inflight] = 1'b1;
        check("rnd resp", bus.resp, eresp);
        check("rnd err", bus.err, 0);
        if (e_we) begin
          check("rnd wr rdata", bus.rdata, last_rd);
          model[e_addr[3:0]] = e_wd;
        end else begin
          check("rnd rd rdata", bus.rdata, model[e_addr[3:0]]);
        end
        last_rd = bus.rdata;
        if (inflight >= 0) begin
          ptr_m = (inflight + 1) % N;
          bus.req[inflight] = 1'b0;
        end
        jd = inflight;
        inflight = -1;
        quiet = 0;
        nresp++;
      end else begin
        quiet++;
      end
      if (quiet > 60) begin
        check("rnd watchdog", quiet, 0);
        abort = 1'b1;
      end
      pm = bus.mem_req;
      for (int k = 0; k < N; k++) begin
        if (k == inflight && bus.mem_req) begin
          bus.we[k] = 1'($urandom);
          bus.addr[k*AW +: AW] = AW'($urandom);
          bus.wdata[k*DW +: DW] = DW'($urandom);
          if ($urandom_range(0, 7) == 0) bus.req[k] = 1'b0;
        end else if (!bus.req[k] && k != jd && k != inflight &&
                     $urandom_range(0, 2) == 0) begin
          bus.we[k] = 1'($urandom);
          bus.addr[k*AW +: AW] = AW'(256 + $urandom_range(0, 15));
          bus.wdata[k*DW +: DW] = DW'($urandom);
          bus.req[k] = 1'b1;
        end
      end
    end
    check("rnd progress", nresp > 100, 1);
    rand_mode = 1'b0;
    bus.req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global time limit: got running, expected finished");
    $fatal(1);
  end
endmodule
